change_dispenser: RTL and testbench

Converts a cents-valued change amount, produced by the vending controller when a purchase overpays or is cancelled, into a sequence of physical coin-eject pulses. It uses greedy denomination selection: dollar, quarter, dime, then nickel. It sits directly downstream of the vending controller and drives the coin-hopper solenoids, one coin per clock. It optionally tracks hopper inventory and reports any amount it could not pay out.

---
 rtl/change_dispenser_pkg.sv | 43 ++++
 rtl/change_dispenser_coin_select.sv | 31 +++
 rtl/change_dispenser.sv | 131 +++++++++++++
 tb/tb_change_dispenser.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Package  : change_pkg
// Brief    : Shared coin values, cents type, FSM states and denomination index.
// Revision : 1.0
// ============================================================================
package change_pkg;

    localparam int unsigned CENTS_W   = 9;
    localparam int unsigned NUM_DENOM = 4;

    typedef logic [CENTS_W-1:0] cents_t;

    localparam cents_t COIN_DOLLAR  = 9'd100;
    localparam cents_t COIN_QUARTER = 9'd25;
    localparam cents_t COIN_DIME    = 9'd10;
    localparam cents_t COIN_NICKEL  = 9'd5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    // Index doubles as bit position in every {dollar, quarter, dime, nickel} vector.
    typedef enum logic [1:0] {
        DENOM_NICKEL  = 2'd0,
        DENOM_DIME    = 2'd1,
        DENOM_QUARTER = 2'd2,
        DENOM_DOLLAR  = 2'd3
    } denom_t;

    function automatic cents_t coin_value(input denom_t d);
        case (d)
            DENOM_DOLLAR:  coin_value = COIN_DOLLAR;
            DENOM_QUARTER: coin_value = COIN_QUARTER;
            DENOM_DIME:    coin_value = COIN_DIME;
            default:       coin_value = COIN_NICKEL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/change_dispenser_coin_select.sv
`default_nettype none
// ============================================================================
// Module   : coin_select
// Brief    : Greedy pick of the largest coin that fits and is in stock.
// Revision : 1.0
// ============================================================================
module coin_select
    import change_pkg::*;
(
    input  cents_t                i_remain,
    input  logic [NUM_DENOM-1:0]  i_avail,
    output logic [NUM_DENOM-1:0]  o_sel,
    output cents_t                o_value
);

    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_sel   = '0;
        o_value = '0;
        for (int i = NUM_DENOM - 1; i >= 0; i--) begin
            if (!w_found && i_avail[i] && (coin_value(denom_t'(i[1:0])) <= i_remain)) begin
                w_found  = 1'b1;
                o_sel[i] = 1'b1;
                o_value  = coin_value(denom_t'(i[1:0]));
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Brief    : Turns a change amount into one-per-clock coin-eject pulses.
//            Define CHANGE_INVENTORY_EN for hopper counters and refill ports.
// Revision : 1.0
// ============================================================================
module change_dispenser
    import change_pkg::*;
#(
    parameter int INV_W      = 8,
    parameter int INIT_COUNT = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [8:0]       req_amount,
    output logic             ready_o,
    output logic             dollar_o,
    output logic             quarter_o,
    output logic             dime_o,
    output logic             nickel_o,
    output logic             done_o,
    output logic [8:0]       short_o
`ifdef CHANGE_INVENTORY_EN
    ,
    input  logic             refill_valid,
    input  logic [3:0]       refill_mask,
    input  logic [INV_W-1:0] refill_count,
    output logic [3:0]       inv_empty_o
`endif
);

    state_t                r_state, w_state_nx;
    cents_t                r_remain, w_remain_nx;
    cents_t                r_short, w_short_nx;
    logic [NUM_DENOM-1:0]  r_coin, w_coin_nx;
    logic                  r_done, w_done_nx;
    logic [NUM_DENOM-1:0]  w_avail;
    logic [NUM_DENOM-1:0]  w_sel;
    cents_t                w_value;

    coin_select u_coin_select (
        .i_remain (r_remain),
        .i_avail  (w_avail),
        .o_sel    (w_sel),
        .o_value  (w_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_short  <= '0;
            r_coin   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_remain <= w_remain_nx;
            r_short  <= w_short_nx;
            r_coin   <= w_coin_nx;
            r_done   <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_remain_nx = r_remain;
        w_short_nx  = r_short;
        w_coin_nx   = '0;
        w_done_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_remain_nx = req_amount;
                    w_short_nx  = '0;
                    w_state_nx  = DISPENSE;
                end
            end
            DISPENSE: begin
                if (|w_sel) begin
                    w_coin_nx   = w_sel;
                    w_remain_nx = r_remain - w_value;
                end else begin
                    w_short_nx = r_remain;
                    w_done_nx  = 1'b1;
                    w_state_nx = DONE;
                end
            end
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

`ifdef CHANGE_INVENTORY_EN
    // w_coin_nx is the one-hot decrement for the coin ejected on this edge.
    for (genvar g = 0; g < NUM_DENOM; g++) begin : g_inv
        logic [INV_W-1:0] r_cnt;
        logic [INV_W:0]   w_sum;
        logic [INV_W:0]   w_next;

        assign w_sum  = {1'b0, r_cnt} +
                        ((refill_valid && refill_mask[g]) ? {1'b0, refill_count} : '0);
        // An eligible coin always has r_cnt > 0, so this never wraps below zero.
        assign w_next = w_sum - {{INV_W{1'b0}}, w_coin_nx[g]};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_cnt <= INV_W'(INIT_COUNT);
            else if (w_next[INV_W])
                r_cnt <= '1;
            else
                r_cnt <= w_next[INV_W-1:0];
        end

        assign w_avail[g] = |r_cnt;
    end

    assign inv_empty_o = ~w_avail;
`else
    localparam logic c_cfg_ok = (INV_W > 0) && (INIT_COUNT >= 0);
    assign w_avail = {NUM_DENOM{c_cfg_ok}};
`endif

    assign ready_o = (r_state == IDLE);
    assign {dollar_o, quarter_o, dime_o, nickel_o} = r_coin;
    assign done_o  = r_done;
    assign short_o = r_short;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Brief    : Directed self-checking bench for change_dispenser.
// Revision : 1.0
// ============================================================================
module tb_change_dispenser;

`ifdef CHANGE_INVENTORY_EN
    localparam int INIT = 1;
`else
    localparam int INIT = 20;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [8:0] req_amount = '0;
    logic       ready_o, dollar_o, quarter_o, dime_o, nickel_o, done_o;
    logic [8:0] short_o;
    logic [3:0] coins;
`ifdef CHANGE_INVENTORY_EN
    logic       refill_valid = 1'b0;
    logic [3:0] refill_mask = '0;
    logic [7:0] refill_count = '0;
    logic [3:0] inv_empty_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    change_dispenser #(
        .INV_W      (8),
        .INIT_COUNT (INIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .ready_o      (ready_o),
        .dollar_o     (dollar_o),
        .quarter_o    (quarter_o),
        .dime_o       (dime_o),
        .nickel_o     (nickel_o),
        .done_o       (done_o),
        .short_o      (short_o)
`ifdef CHANGE_INVENTORY_EN
        ,
        .refill_valid (refill_valid),
        .refill_mask  (refill_mask),
        .refill_count (refill_count),
        .inv_empty_o  (inv_empty_o)
`endif
    );

    assign coins = {dollar_o, quarter_o, dime_o, nickel_o};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // seq holds one coin nibble per eject, first coin in the most significant used nibble.
    task automatic run_req(input string tag, input logic [8:0] amt, input logic [31:0] seq,
                           input int n, input logic [8:0] exp_short, input bit hold,
                           input logic [3:0] rmask, input logic [7:0] rcnt);
        check({tag, ":ready_before"}, 32'(ready_o), 32'd1);
        req_valid  = 1'b1;
        req_amount = amt;
        @(negedge clk);
        check({tag, ":busy_after_E0"}, 32'(ready_o), 32'd0);
        if (!hold) req_valid = 1'b0;
`ifdef CHANGE_INVENTORY_EN
        refill_valid = (rmask != 4'b0);
        refill_mask  = rmask;
        refill_count = rcnt;
`else
        if (rmask != 4'b0 || rcnt != 8'd0) $display("note: refill ignored without inventory");
`endif
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
`ifdef CHANGE_INVENTORY_EN
            refill_valid = 1'b0;
`endif
            check($sformatf("%s:coin%0d", tag, k + 1), {27'd0, done_o, coins},
                  {27'd0, 1'b0, 4'((seq >> (4 * (n - 1 - k))) & 32'hF)});
        end
        @(negedge clk);
`ifdef CHANGE_INVENTORY_EN
        refill_valid = 1'b0;
`endif
        check({tag, ":done"}, {27'd0, done_o, coins}, 32'h10);
        check({tag, ":short"}, 32'(short_o), 32'(exp_short));
        @(negedge clk);
        check({tag, ":ready_after"}, {30'd0, ready_o, done_o}, 32'h2);
        req_valid = 1'b0;
        if (hold) begin
            @(negedge clk);
            check({tag, ":no_reaccept"}, {27'd0, ready_o, coins}, 32'h10);
        end
    endtask

    initial begin
        #1;
        check("reset:ready", 32'(ready_o), 32'd1);
        check("reset:outs", {26'd0, done_o, coins}, 32'd0);
        check("reset:short", 32'(short_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_req("a125", 9'd125, 32'h84, 2, 9'd0, 1'b0, 4'b0, 8'd0);
        do_reset();
        run_req("a40", 9'd40, 32'h421, 3, 9'd0, 1'b0, 4'b0, 8'd0);
        do_reset();
        run_req("a0", 9'd0, 32'h0, 0, 9'd0, 1'b0, 4'b0, 8'd0);
        run_req("a7", 9'd7, 32'h1, 1, 9'd2, 1'b0, 4'b0, 8'd0);
        do_reset();
        run_req("a3", 9'd3, 32'h0, 0, 9'd3, 1'b0, 4'b0, 8'd0);
`ifndef CHANGE_INVENTORY_EN
        run_req("a511", 9'd511, 32'h888882, 6, 9'd1, 1'b0, 4'b0, 8'd0);
`endif
        do_reset();
        run_req("hold125", 9'd125, 32'h84, 2, 9'd0, 1'b1, 4'b0, 8'd0);

        // Reset pulled while the first dollar of 300 is on the output.
        do_reset();
        req_valid  = 1'b1;
        req_amount = 9'd300;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst300:dollar", 32'(coins), 32'h8);
`ifdef CHANGE_INVENTORY_EN
        check("rst300:empty_before", 32'(inv_empty_o), 32'h8);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst300:drop", {26'd0, ready_o, done_o, coins}, 32'h20);
`ifdef CHANGE_INVENTORY_EN
        check("rst300:counters", 32'(inv_empty_o), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rst300:quiet%0d", c), {27'd0, ready_o, coins}, 32'h10);
        end

`ifdef CHANGE_INVENTORY_EN
        do_reset();
        run_req("i60", 9'd60, 32'h421, 3, 9'd20, 1'b0, 4'b0, 8'd0);
        run_req("i30", 9'd30, 32'h0, 0, 9'd30, 1'b0, 4'b0, 8'd0);
        check("i30:empty", 32'(inv_empty_o), 32'h7);
        do_reset();
        run_req("refill25", 9'd25, 32'h4, 1, 9'd0, 1'b0, 4'b0100, 8'd3);
        run_req("r75", 9'd75, 32'h444, 3, 9'd0, 1'b0, 4'b0, 8'd0);
        check("r75:empty", 32'(inv_empty_o), 32'h4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
